// File: rtl/prog_loader.sv
// Boot loader: assembles a LEN/HI/LO.../CSUM byte stream into 16-bit words and writes instruction memory.
// Latency: a memory write is issued one cycle after the LO byte of each word is accepted.
// Backpressure: rx_ready is high only in LEN/HI/LO/CSUM; the gap between bytes is unbounded.
module prog_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so a full image of DEPTH words is representable.
    localparam int WC_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              len_bad;
    logic              last_word;
    logic [WC_W-1:0]   nwords;
    logic [WC_W-1:0]   widx;
    logic [7:0]        hi_byte;
    logic [7:0]        csum;

    assign accept    = rx_valid && rx_ready;
    assign len_bad   = (rx_byte == 8'd0) || (int'({24'd0, rx_byte}) > DEPTH);
    assign last_word = (widx == nwords - WC_W'(1));

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN;
            end
            S_LEN: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = len_bad ? S_ERR : S_HI;
            end
            S_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = S_LO;
            end
            S_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = last_word ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = (rx_byte == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_nxt = S_LEN;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nxt = S_LEN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: word count, byte latch, running checksum and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            nwords   <= '0;
            widx     <= '0;
            hi_byte  <= '0;
            csum     <= '0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_wr <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        csum <= '0;
                        widx <= '0;
                    end
                end
                S_LEN: begin
                    if (accept && !len_bad) nwords <= WC_W'(rx_byte);
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte <= rx_byte;
                        csum    <= csum ^ rx_byte;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        csum     <= csum ^ rx_byte;
                        mem_wr   <= 1'b1;
                        // widx is below DEPTH here, so the truncation never wraps.
                        mem_addr <= widx[ADDR_W-1:0];
                        mem_data <= {hi_byte, rx_byte};
                        widx     <= widx + WC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
